// File: rtl/snn_feeder_pkg.sv
// Shared constants, state encoding and emit payload for the SNN input feeder.
package snn_feeder_pkg;

    localparam int unsigned IMG_BYTES_DEF = 72;
    localparam int unsigned KER_BYTES_DEF = 9;
    localparam int unsigned W_BYTES_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF   = 255;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned RES_W      = 10;
    localparam int unsigned BYTE_CNT_W = 7;
    localparam int unsigned EMIT_CNT_W = 7;
    localparam int unsigned WAIT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_EMIT = 2'd1,
        ST_WAIT = 2'd2
    } feeder_state_e;

    // One EMIT beat as presented to the SNN core.
    typedef struct packed {
        logic [DATA_W-1:0] img;
        logic [DATA_W-1:0] ker;
        logic [DATA_W-1:0] weight;
    } snn_beat_t;

    // Address width for a buffer of n entries, never narrower than one bit.
    function automatic int unsigned idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snn_feeder_if.sv
// Byte-stream, SNN-core and result signals of the feeder; slave is the feeder side.
interface snn_feeder_if;
    import snn_feeder_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    logic              snn_in_valid;
    logic [DATA_W-1:0] snn_img;
    logic [DATA_W-1:0] snn_ker;
    logic [DATA_W-1:0] snn_weight;
    logic              snn_out_valid;
    logic [RES_W-1:0]  snn_out_data;

    logic              res_valid;
    logic [RES_W-1:0]  res_data;
    logic              err;

    modport master (
        output s_valid, s_data, snn_out_valid, snn_out_data,
        input  s_ready, snn_in_valid, snn_img, snn_ker, snn_weight,
               res_valid, res_data, err
    );

    modport slave (
        input  s_valid, s_data, snn_out_valid, snn_out_data,
        output s_ready, snn_in_valid, snn_img, snn_ker, snn_weight,
               res_valid, res_data, err
    );

endinterface

// File: rtl/snn_feeder.sv
// Buffers one weight/kernel/image frame from a byte stream, replays it to the
// SNN core as a burst of IMG_BYTES beats, then waits for the result or a timeout.
module snn_feeder
    import snn_feeder_pkg::*;
#(
    parameter int unsigned IMG_BYTES = IMG_BYTES_DEF,
    parameter int unsigned KER_BYTES = KER_BYTES_DEF,
    parameter int unsigned W_BYTES   = W_BYTES_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    snn_feeder_if.slave  bus
);

    localparam int unsigned FRAME_BYTES = W_BYTES + KER_BYTES + IMG_BYTES;
    localparam int unsigned IMG_AW      = idx_w(IMG_BYTES);
    localparam int unsigned KER_AW      = idx_w(KER_BYTES);
    localparam int unsigned W_AW        = idx_w(W_BYTES);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE  = BYTE_CNT_W'(FRAME_BYTES - 1);
    localparam logic [BYTE_CNT_W-1:0] KER_BASE   = BYTE_CNT_W'(W_BYTES);
    localparam logic [BYTE_CNT_W-1:0] IMG_BASE   = BYTE_CNT_W'(W_BYTES + KER_BYTES);
    localparam logic [EMIT_CNT_W-1:0] EMIT_END   = EMIT_CNT_W'(IMG_BYTES);
    localparam logic [EMIT_CNT_W-1:0] EMIT_KER   = EMIT_CNT_W'(KER_BYTES);
    localparam logic [EMIT_CNT_W-1:0] EMIT_W     = EMIT_CNT_W'(W_BYTES);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(TIMEOUT);

    feeder_state_e          r_state;
    logic [BYTE_CNT_W-1:0]  r_byte_cnt;
    logic [EMIT_CNT_W-1:0]  r_emit_cnt;
    logic [WAIT_CNT_W-1:0]  r_wait_cnt;
    logic                   r_s_ready;
    logic                   r_in_valid;
    snn_beat_t              r_beat;
    logic                   r_res_valid;
    logic [RES_W-1:0]       r_res_data;
    logic                   r_err;

    logic [DATA_W-1:0]      r_img [IMG_BYTES];
    logic [DATA_W-1:0]      r_ker [KER_BYTES];
    logic [DATA_W-1:0]      r_w   [W_BYTES];

    logic                   w_xfer;
    snn_beat_t              w_beat;

    assign w_xfer = (r_state == ST_LOAD) && r_s_ready && bus.s_valid;

    // Frame buffers hold no reset; every byte is rewritten before it is replayed.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            if (r_byte_cnt < KER_BASE) begin
                r_w[W_AW'(r_byte_cnt)] <= bus.s_data;
            end else if (r_byte_cnt < IMG_BASE) begin
                r_ker[KER_AW'(r_byte_cnt - KER_BASE)] <= bus.s_data;
            end else begin
                r_img[IMG_AW'(r_byte_cnt - IMG_BASE)] <= bus.s_data;
            end
        end
    end

    // Beat for emit index r_emit_cnt; kernel and weight lanes run out early and read 0.
    always_comb begin
        w_beat = '0;
        if (r_emit_cnt < EMIT_END) begin
            w_beat.img = r_img[IMG_AW'(r_emit_cnt)];
        end
        if (r_emit_cnt < EMIT_KER) begin
            w_beat.ker = r_ker[KER_AW'(r_emit_cnt)];
        end
        if (r_emit_cnt < EMIT_W) begin
            w_beat.weight = r_w[W_AW'(r_emit_cnt)];
        end
    end

    // Control FSM; r_emit_cnt is kept at 0 outside EMIT so the first beat is ready on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_byte_cnt  <= '0;
            r_emit_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_s_ready   <= 1'b0;
            r_in_valid  <= 1'b0;
            r_beat      <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    r_s_ready <= 1'b1;
                    if (w_xfer) begin
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_state    <= ST_EMIT;
                            r_s_ready  <= 1'b0;
                            r_in_valid <= 1'b1;
                            r_beat     <= w_beat;
                            r_emit_cnt <= EMIT_CNT_W'(1);
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (r_emit_cnt == EMIT_END) begin
                        r_state    <= ST_WAIT;
                        r_in_valid <= 1'b0;
                        r_beat     <= '0;
                        r_emit_cnt <= '0;
                        r_wait_cnt <= '0;
                    end else begin
                        r_beat     <= w_beat;
                        r_emit_cnt <= r_emit_cnt + EMIT_CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    // A result arriving on the timeout cycle wins over the abort.
                    if (bus.snn_out_valid) begin
                        r_res_data  <= bus.snn_out_data;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_LOAD;
                        r_s_ready   <= 1'b1;
                        r_byte_cnt  <= '0;
                    end else if (r_wait_cnt == WAIT_LIMIT) begin
                        r_err      <= 1'b1;
                        r_state    <= ST_LOAD;
                        r_s_ready  <= 1'b1;
                        r_byte_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_LOAD;
                    r_s_ready  <= 1'b0;
                    r_in_valid <= 1'b0;
                    r_beat     <= '0;
                    r_byte_cnt <= '0;
                    r_emit_cnt <= '0;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.s_ready      = r_s_ready;
    assign bus.snn_in_valid = r_in_valid;
    assign bus.snn_img      = r_beat.img;
    assign bus.snn_ker      = r_beat.ker;
    assign bus.snn_weight   = r_beat.weight;
    assign bus.res_valid    = r_res_valid;
    assign bus.res_data     = r_res_data;
    assign bus.err          = r_err;

endmodule

// File: tb/tb_snn_feeder.sv
// Self-checking bench for snn_feeder: frame load, emit replay, result capture,
// timeout abort and reset during emit, against a frame-level reference model.
module tb_snn_feeder;

    localparam int IMG   = 72;
    localparam int KER   = 9;
    localparam int WB    = 4;
    localparam int TMO   = 255;
    localparam int FRAME = WB + KER + IMG;

    logic clk;
    logic rst_n;

    snn_feeder_if bus ();

    snn_feeder #(
        .IMG_BYTES (IMG),
        .KER_BYTES (KER),
        .W_BYTES   (WB),
        .TIMEOUT   (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  w_m   [WB];
    logic [7:0]  ker_m [KER];
    logic [7:0]  img_m [IMG];
    logic [7:0]  frame [FRAME];
    logic        obs_v    [IMG+1];
    logic [23:0] obs_beat [IMG+1];

    int g_ready_low;
    int g_early_valid;
    int g_res_high;
    bit g_load_ok;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: fixed ramp pattern or random bytes, stored weight, kernel, image.
    task automatic new_frame(input bit fixed);
        for (int i = 0; i < WB; i++)  w_m[i]   = fixed ? 8'(i + 1)  : 8'($urandom);
        for (int i = 0; i < KER; i++) ker_m[i] = fixed ? 8'(i + 10) : 8'($urandom);
        for (int i = 0; i < IMG; i++) img_m[i] = fixed ? 8'(i)      : 8'($urandom);
        for (int i = 0; i < WB; i++)  frame[i] = w_m[i];
        for (int i = 0; i < KER; i++) frame[WB + i] = ker_m[i];
        for (int i = 0; i < IMG; i++) frame[WB + KER + i] = img_m[i];
    endtask

    // Expected {img, ker, weight} on emit beat k; beyond the burst everything is 0.
    function automatic logic [23:0] model_beat(int k);
        logic [7:0] i_b, k_b, w_b;
        i_b = (k < IMG) ? img_m[k] : 8'd0;
        k_b = (k < KER) ? ker_m[k] : 8'd0;
        w_b = (k < WB)  ? w_m[k]   : 8'd0;
        return {i_b, k_b, w_b};
    endfunction

    // Streams the frame; mode 0 back-to-back, 1 alternating gaps, 2 random gaps.
    task automatic send_frame(input int mode, input bit noise);
        int idx   = 0;
        int guard = 0;
        bit phase = 1'b0;
        bit v;
        g_ready_low   = 0;
        g_early_valid = 0;
        g_res_high    = 0;
        while (idx < FRAME && guard < 2000) begin
            if (bus.snn_in_valid) g_early_valid++;
            if (bus.res_valid) g_res_high++;
            case (mode)
                0:       v = 1'b1;
                1:       v = ~phase;
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.s_valid = v;
            bus.s_data  = v ? frame[idx] : 8'($urandom);
            if (noise) begin
                bus.snn_out_valid = 1'($urandom_range(0, 1));
                bus.snn_out_data  = 10'($urandom);
            end
            if (!bus.s_ready) g_ready_low++;
            else if (v) idx++;
            phase = ~phase;
            step();
            guard++;
        end
        bus.s_valid       = 1'b0;
        bus.snn_out_valid = 1'b0;
        g_load_ok = (idx == FRAME);
    endtask

    // Records emit beats 0..IMG, ending at the first WAIT cycle.
    task automatic capture_emit();
        for (int k = 0; k <= IMG; k++) begin
            obs_v[k]    = bus.snn_in_valid;
            obs_beat[k] = {bus.snn_img, bus.snn_ker, bus.snn_weight};
            if (k < IMG) step();
        end
    endtask

    task automatic test_reset();
        logic [37:0] outs;
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.snn_out_valid = 1'b0;
        bus.snn_out_data = '0;
        repeat (3) @(posedge clk);
        #1;
        outs = {bus.s_ready, bus.snn_in_valid, bus.snn_img, bus.snn_ker, bus.snn_weight,
                bus.res_valid, bus.res_data, bus.err};
        checks++;
        if (outs !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 0 before first clock", bus.s_ready);
        end
        step();
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_clock_ready: got %b, required 1", bus.s_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        new_frame(1'b1);
        send_frame(0, 1'b0);
        checks++;
        if (!g_load_ok || g_early_valid != 0) begin
            errors++;
            $display("FAIL b2b_load: ok=%0b early_valid=%0d, required ok=1 early_valid=0",
                     g_load_ok, g_early_valid);
        end
        capture_emit();
        for (int k = 0; k <= IMG; k++) begin
            exp_v = (k < IMG);
            checks++;
            if (obs_v[k] !== exp_v || obs_beat[k] !== model_beat(k)) begin
                errors++;
                $display("FAIL b2b_emit[%0d]: got v=%b beat=%h, required v=%b beat=%h",
                         k, obs_v[k], obs_beat[k], exp_v, model_beat(k));
            end
        end
    endtask

    // Continues from the WAIT state left by test_back_to_back.
    task automatic test_result();
        int early = 0;
        for (int c = 0; c < 40; c++) begin
            bus.snn_out_valid = 1'b0;
            step();
            if (bus.res_valid || bus.err || bus.s_ready) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL result_wait_quiet: got %0d noisy cycles, required 0", early);
        end
        bus.snn_out_valid = 1'b1;
        bus.snn_out_data  = 10'd37;
        step();
        bus.snn_out_valid = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 10'd37 || bus.err !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL result_capture: got v=%b d=%0d err=%b rdy=%b, required v=1 d=37 err=0 rdy=1",
                     bus.res_valid, bus.res_data, bus.err, bus.s_ready);
        end
        step();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 10'd37) begin
            errors++;
            $display("FAIL result_pulse: got v=%b d=%0d, required v=0 d=37", bus.res_valid, bus.res_data);
        end
    endtask

    task automatic test_gapped();
        logic       exp_v;
        int         n;
        logic [9:0] d;
        new_frame(1'b1);
        send_frame(1, 1'b1);
        checks++;
        if (!g_load_ok || g_ready_low != 0) begin
            errors++;
            $display("FAIL gap_load: ok=%0b ready_low=%0d, required ok=1 ready_low=0", g_load_ok, g_ready_low);
        end
        checks++;
        if (g_res_high != 0 || bus.res_data !== 10'd37) begin
            errors++;
            $display("FAIL gap_ignore_out_valid: res_pulses=%0d res_data=%0d, required 0 and 37",
                     g_res_high, bus.res_data);
        end
        capture_emit();
        for (int k = 0; k <= IMG; k++) begin
            exp_v = (k < IMG);
            checks++;
            if (obs_v[k] !== exp_v || obs_beat[k] !== model_beat(k)) begin
                errors++;
                $display("FAIL gap_emit[%0d]: got v=%b beat=%h, required v=%b beat=%h",
                         k, obs_v[k], obs_beat[k], exp_v, model_beat(k));
            end
        end
        n = $urandom_range(0, 200);
        d = 10'($urandom);
        repeat (n) step();
        bus.snn_out_valid = 1'b1;
        bus.snn_out_data  = d;
        step();
        bus.snn_out_valid = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== d || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL gap_result: got v=%b d=%0d err=%b, required v=1 d=%0d err=0",
                     bus.res_valid, bus.res_data, bus.err, d);
        end
        step();
    endtask

    task automatic test_timeout();
        int n = 0;
        int res_hi = 0;
        logic exp_v;
        new_frame(1'b0);
        send_frame(2, 1'b0);
        capture_emit();
        for (int k = 0; k <= IMG; k++) begin
            exp_v = (k < IMG);
            checks++;
            if (obs_v[k] !== exp_v || obs_beat[k] !== model_beat(k)) begin
                errors++;
                $display("FAIL rand_emit[%0d]: got v=%b beat=%h, required v=%b beat=%h",
                         k, obs_v[k], obs_beat[k], exp_v, model_beat(k));
            end
        end
        while (bus.err !== 1'b1 && n < 400) begin
            bus.snn_out_valid = 1'b0;
            step();
            n++;
            if (bus.res_valid) res_hi++;
        end
        // WAIT cycles 0..TMO elapse; the abort is visible on the cycle after cycle TMO.
        checks++;
        if (n != TMO + 1) begin
            errors++;
            $display("FAIL timeout_cycle: err after %0d cycles, required %0d", n, TMO + 1);
        end
        checks++;
        if (res_hi != 0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_state: res_pulses=%0d rdy=%b, required 0 and 1", res_hi, bus.s_ready);
        end
        step();
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got err=%b, required 0", bus.err);
        end
    endtask

    task automatic test_simultaneous();
        int         err_early = 0;
        logic [9:0] d;
        new_frame(1'b0);
        send_frame(0, 1'b0);
        capture_emit();
        for (int c = 0; c < TMO; c++) begin
            step();
            if (bus.err || bus.res_valid) err_early++;
        end
        d = 10'($urandom);
        bus.snn_out_valid = 1'b1;
        bus.snn_out_data  = d;
        step();
        bus.snn_out_valid = 1'b0;
        checks++;
        if (err_early != 0 || bus.res_valid !== 1'b1 || bus.err !== 1'b0 || bus.res_data !== d) begin
            errors++;
            $display("FAIL simultaneous: early=%0d v=%b err=%b d=%0d, required early=0 v=1 err=0 d=%0d",
                     err_early, bus.res_valid, bus.err, bus.res_data, d);
        end
        step();
        checks++;
        if (bus.err !== 1'b0 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL simultaneous_after: err=%b v=%b, required 0 0", bus.err, bus.res_valid);
        end
    endtask

    task automatic test_reset_mid_emit();
        logic        exp_v;
        logic [24:0] outs;
        int          n;
        logic [9:0]  d;
        new_frame(1'b0);
        send_frame(0, 1'b0);
        repeat (30) step();
        checks++;
        if (bus.snn_in_valid !== 1'b1 || {bus.snn_img, bus.snn_ker, bus.snn_weight} !== model_beat(30)) begin
            errors++;
            $display("FAIL mid_emit_beat30: got v=%b beat=%h, required v=1 beat=%h", bus.snn_in_valid,
                     {bus.snn_img, bus.snn_ker, bus.snn_weight}, model_beat(30));
        end
        #1 rst_n = 1'b0;
        #1;
        outs = {bus.snn_in_valid, bus.snn_img, bus.snn_ker, bus.snn_weight};
        checks++;
        if (outs !== 25'd0 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_emit_reset: got %h rdy=%b, required 0 0", outs, bus.s_ready);
        end
        step();
        rst_n = 1'b1;
        step();
        new_frame(1'b0);
        send_frame(2, 1'b0);
        checks++;
        if (!g_load_ok || g_early_valid != 0) begin
            errors++;
            $display("FAIL mid_emit_no_resume: ok=%0b early_valid=%0d, required ok=1 early_valid=0",
                     g_load_ok, g_early_valid);
        end
        capture_emit();
        for (int k = 0; k <= IMG; k++) begin
            exp_v = (k < IMG);
            checks++;
            if (obs_v[k] !== exp_v || obs_beat[k] !== model_beat(k)) begin
                errors++;
                $display("FAIL post_reset_emit[%0d]: got v=%b beat=%h, required v=%b beat=%h",
                         k, obs_v[k], obs_beat[k], exp_v, model_beat(k));
            end
        end
        n = $urandom_range(0, 250);
        d = 10'($urandom);
        repeat (n) step();
        bus.snn_out_valid = 1'b1;
        bus.snn_out_data  = d;
        step();
        bus.snn_out_valid = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== d) begin
            errors++;
            $display("FAIL post_reset_result: got v=%b d=%0d, required v=1 d=%0d", bus.res_valid, bus.res_data, d);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_result();
        test_gapped();
        test_timeout();
        test_simultaneous();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snn_feeder.md
SNN_FEEDER -- requirements
Module: snn_feeder

Interface
REQ-001 SHALL have parameter IMG_BYTES, default 72, image bytes per frame (two 6x6 images, A then B).
REQ-002 SHALL have parameter KER_BYTES, default 9, kernel bytes per frame.
REQ-003 SHALL have parameter W_BYTES, default 4, weight bytes per frame.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abort.
REQ-005 SHALL have port clk input 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-007 SHALL have port s_valid input 1, upstream byte valid.
REQ-008 SHALL have port s_ready output 1, feeder can accept a byte.
REQ-009 SHALL have port s_data input 8, upstream byte.
REQ-010 SHALL have port snn_in_valid output 1, drives SNN in_valid.
REQ-011 SHALL have ports snn_img, snn_ker and snn_weight, each output 8, driving SNN img, ker and weight.
REQ-012 SHALL have port snn_out_valid input 1, SNN out_valid.
REQ-013 SHALL have port snn_out_data input 10, SNN out_data.
REQ-014 SHALL have port res_valid output 1, one-cycle result pulse.
REQ-015 SHALL have port res_data output 10, captured SNN result.
REQ-016 SHALL have port err output 1, one-cycle timeout pulse.

Function
REQ-017 SHALL implement states LOAD, EMIT and WAIT.
REQ-018 SHALL transfer a byte in LOAD only on a cycle with s_valid=1 and s_ready=1.
REQ-019 SHALL take each frame in fixed order: W_BYTES weight bytes, then KER_BYTES kernel bytes, then IMG_BYTES image bytes (85 total), each stored in its own buffer.
REQ-020 SHALL hold s_ready=1 in LOAD and s_ready=0 in EMIT and WAIT.
REQ-021 SHALL, in LOAD, never stall on s_valid=0 gaps; the byte counter holds across gaps.
REQ-022 SHALL go LOAD->EMIT on the cycle after the 85th byte transfers.
REQ-023 SHALL, in EMIT, assert snn_in_valid for exactly IMG_BYTES consecutive cycles, with no bubbles.
REQ-024 SHALL, on EMIT cycle k (k=0..71), drive snn_img=img[k].
REQ-025 SHALL, on EMIT cycle k, drive snn_ker=ker[k] for k<9, else 0.
REQ-026 SHALL, on EMIT cycle k, drive snn_weight=w[k] for k<4, else 0.
REQ-027 SHALL drive snn_in_valid and all snn_* data outputs from registers, and hold them at 0 outside EMIT.
REQ-028 SHALL go EMIT->WAIT after cycle 71; the WAIT counter starts at 0.
REQ-029 SHALL, in WAIT with snn_out_valid=1, register res_data=snn_out_data, pulse res_valid for 1 cycle on the next cycle, and go to LOAD.
REQ-030 SHALL, in WAIT, pulse err for 1 cycle and go to LOAD if the counter reaches TIMEOUT with no snn_out_valid.
REQ-031 SHALL give snn_out_valid priority over timeout when both occur in the same cycle, with no err.
REQ-032 SHALL ignore snn_out_valid outside WAIT.
REQ-033 SHALL hold res_data until the next capture.
REQ-034 SHALL size all counters to their maximum with no wrap: byte 7 bits, emit 7 bits, wait 8 bits.
REQ-035 SHALL reset the byte counter to 0 on each LOAD entry.

Reset
REQ-036 SHALL, on rst_n low, immediately set state=LOAD, clear all counters, and drive s_ready=0, snn_in_valid=0, snn_img=snn_ker=snn_weight=0, res_valid=0, res_data=0, err=0.
REQ-037 SHALL assert s_ready=1 on the first clock after rst_n deasserts.
REQ-038 SHALL not reset the frame buffers; their contents are don't-care until rewritten.
REQ-039 SHALL, on reset mid-EMIT, drop snn_in_valid asynchronously and not resume the frame.

Structure
REQ-040 SHALL take the state encoding and the parameter defaults 72/9/4/255 from the shared SNN package.
REQ-041 SHALL use no sub-module; the byte buffers SHALL be flat register arrays inside snn_feeder.

Verification
REQ-042 Bench SHALL cover back-to-back load: 85 bytes with s_valid held high, weights 1..4, ker 10..18, img 0..71 -> EMIT starts 1 cycle after the last byte; snn_weight reads 1,2,3,4,0...; snn_ker reads 10..18 then 0; snn_img reads 0..71; snn_in_valid high for exactly 72 cycles.
REQ-043 Bench SHALL cover gapped load: s_valid toggling 1/0 -> the same emitted sequence as REQ-042, and s_ready stays 1 throughout LOAD.
REQ-044 Bench SHALL cover the result path: snn_out_valid=1 with data 10'd37 at WAIT cycle 40 -> res_valid pulses once with res_data=37, then s_ready=1.
REQ-045 Bench SHALL cover timeout: no snn_out_valid -> err pulses once at WAIT cycle 255, res_valid stays 0, state returns to LOAD.
REQ-046 Bench SHALL cover simultaneous events: snn_out_valid on the timeout cycle -> res_valid=1 and err=0.
REQ-047 Bench SHALL cover reset at EMIT cycle 30 -> snn_in_valid=0 at once, and a full new 85-byte frame emits correctly afterwards.
